cpu_bus_interface: RTL and testbench
====================================

Name: cpu_bus_interface

Overview:
Sits between the 8227 core's external pins and a request/acknowledge memory port, downstream of the core and feeding back into it. The core can stall on reads (ready) but never on writes, so the block posts writes into a small in-order buffer, drains them to memory, and holds ready low on a read until the write buffer is empty and read data has been captured. It converts the core's one-access-per-clock bus into a variable-latency handshake bus.

Parameters:
WB_DEPTH, 4, write-buffer entries; power of two, at least 2; 4 covers the 3 back-to-back interrupt pushes.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
addr_high  in  8  core AddressBusHigh
addr_low  in  8  core AddressBusLow
data_from_cpu  in  8  core dataBusOutput
read_not_write  in  1  core bus direction; 1 = read
sync  in  1  core opcode-fetch marker; used only by the optional feature
ready  out  1  to core ready input
data_to_cpu  out  8  to core dataBusInput; registered read data
mem_req  out  1  memory request
mem_we  out  1  1 = write transfer
mem_addr  out  16  {addr_high, addr_low} or buffered write address
mem_wdata  out  8  write data
mem_ack  in  1  memory accept; a transfer completes on the clk edge where mem_req and mem_ack are both 1
mem_rdata  in  8  read data, valid when mem_ack is 1 on a read
wb_empty  out  1  write buffer empty
wr_overflow  out  1  sticky flag: a write was dropped because the buffer was full

Behaviour:
- Reset values (the rst cycle and after): state IDLE, buffer empty, ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data_to_cpu=0x00, wb_empty=1, wr_overflow=0. An in-flight memory transfer is abandoned; mem_req drops in the rst cycle.
- Write cycle (read_not_write=0): the entry {addr, data} is pushed at the clock edge; ready=1 combinationally. Push and pop in the same cycle are allowed. If a push arrives with the buffer full and no pop that cycle, the write is dropped and wr_overflow is set; it clears only on rst.
- Memory arbitration: a non-empty buffer always drives mem_req with the head entry (mem_we=1). The head pops on req&ack. Order is strictly FIFO. A write transfer ignores mem_rdata.
- FSM states are IDLE, RD_WAIT and RD_DONE.
- IDLE: if read_not_write=1 and the buffer is empty, drive a read request (mem_req=1, mem_we=0, mem_addr = current core address) in the same cycle.
  - On ack: capture mem_rdata into data_to_cpu and go to RD_DONE.
  - Without ack: latch the address and go to RD_WAIT.
  - If the buffer is non-empty, a read stays pending in IDLE while writes drain; ready=0.
- RD_WAIT: hold mem_req with the latched address. On ack, capture data and go to RD_DONE. ready=0.
- RD_DONE: ready=1 for exactly one cycle, then go to IDLE unconditionally. In IDLE, evaluation of the next core access happens the same cycle.
- Latency: zero-wait memory with an empty buffer gives ready low for 1 cycle and high the next. Each memory wait cycle or pending write adds one cycle.
- While in IDLE with read_not_write=1, ready is 0 except via the optional bypass.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1 without ack. When mem_req=0 they hold their last values.
- The core address is stable while ready=0. A read never overtakes a buffered write unless the optional bypass applies.

Optional Feature:
READ_BYPASS_EN.
- Defined: in IDLE, a read whose address matches any buffered entry completes from the buffer without draining or touching memory. Data comes from the youngest match. data_to_cpu is loaded at the edge and the FSM goes to RD_DONE with the same 1-cycle stall.
- sync=1 reads (opcode fetches) never bypass.
- Undefined: all reads wait for wb_empty.

Decomposition:
- Package cpu_bus_pkg holds:
  - bus_state_t enum (IDLE, RD_WAIT, RD_DONE)
  - wb_entry_t packed struct {addr 16, data 8}
  - WB_DEPTH_DEFAULT = 4
- One sub-module, cpu_write_buffer: synchronous FIFO of wb_entry_t with push, pop, full, empty and count. Under READ_BYPASS_EN it also provides a parallel address-match port.

Test Plan:
- Reset: rst=1 for 2 cycles with mem_ack=1 and read_not_write=1 -> ready=0, mem_req=0, data_to_cpu=0x00, wb_empty=1, wr_overflow=0.
- Zero-wait read: mem_ack=1, read 0xFFFC, mem_rdata=0x34 -> cycle0 mem_req=1, mem_we=0, mem_addr=0xFFFC, ready=0; cycle1 ready=1, data_to_cpu=0x34.
- Posted writes: mem_ack=0, writes 0x01FF=0xAA, 0x01FE=0xBB, 0x01FD=0xCC -> ready=1 each cycle, wb_empty=0. Then mem_ack=1 -> three write transfers in that order on consecutive cycles, then wb_empty=1.
- Read ordering: 2 writes buffered, then read 0x0200, ack after 2 cycles -> no read request until both writes are acked; ready stays 0 until the cycle after the read ack.
- Overflow: WB_DEPTH=4, mem_ack=0, 5 writes -> wr_overflow=1 after the 5th and stays set; only the first 4 entries drain once ack rises.
- Wait states: read 0x1234, mem_ack delayed 3 cycles -> mem_addr held at 0x1234, ready=0 for 4 cycles, ready=1 on the 5th.
- With READ_BYPASS_EN: write 0x0010=0x55 buffered (ack=0), read 0x0010 with sync=0 -> ready=1 after 1 cycle with data 0x55 and no memory read. The same access with sync=1 waits for the drain.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types and defaults for the 8227 core bus interface.
package cpu_bus_pkg;

    localparam int WB_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} bus_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/cpu_bus_if.sv
// cpu_bus_if: request/acknowledge memory port; a transfer completes on an edge with mem_req and mem_ack high.
interface cpu_bus_if;

    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);

endinterface

// File: rtl/cpu_write_buffer.sv
// cpu_write_buffer: in-order posted-write FIFO; READ_BYPASS_EN adds a youngest-match address lookup.
module cpu_write_buffer
    import cpu_bus_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  wb_entry_t               pushEntry,
    input  logic                    pop,
    output wb_entry_t               head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef READ_BYPASS_EN
    ,
    input  logic [15:0]             matchAddr,
    output logic                    matchHit,
    output logic [7:0]              matchData
`endif
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic          doPush, doPop;

    assign full   = count == (PW+1)'(DEPTH);
    assign empty  = count == '0;
    assign doPop  = pop && !empty;
    // A pop in the same cycle frees the slot a full-buffer push needs.
    assign doPush = push && (!full || doPop);
    assign head   = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushEntry;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) rdPtr <= rdPtr + 1'b1;
            count <= count + (PW+1)'(doPush) - (PW+1)'(doPop);
        end
    end

`ifdef READ_BYPASS_EN
    // Scan oldest to youngest so the last hit is the youngest match.
    always_comb begin
        matchHit  = 1'b0;
        matchData = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW+1)'(i) < count && mem[rdPtr + PW'(i)].addr == matchAddr) begin
                matchHit  = 1'b1;
                matchData = mem[rdPtr + PW'(i)].data;
            end
        end
    end
`endif

endmodule

// File: rtl/cpu_bus_interface.sv
// cpu_bus_interface: posts 8227 core writes, stalls reads behind them, and drives a req/ack memory port.
// Optional READ_BYPASS_EN lets non-fetch reads complete from a matching buffered write.
module cpu_bus_interface
    import cpu_bus_pkg::*;
#(
    parameter int WB_DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       addr_high,
    input  logic [7:0]       addr_low,
    input  logic [7:0]       data_from_cpu,
    input  logic             read_not_write,
    input  logic             sync,
    output logic             ready,
    output logic [7:0]       data_to_cpu,
    cpu_bus_if.master        bus,
    output logic             wb_empty,
    output logic             wr_overflow
);

    bus_state_t                 state, nextState;
    wb_entry_t                  head;
    logic [$clog2(WB_DEPTH):0]  count;
    logic                       full, empty, hasWrite, push, pop;
    logic                       readIssue, readAck, bypassHit, matchHit;
    logic [7:0]                 matchData, dataToCpu, lastWdata;
    logic [15:0]                coreAddr, rdAddr, curAddr, lastAddr;
    logic                       lastWe, overflow;

    assign coreAddr = {addr_high, addr_low};
    assign hasWrite = !empty;
    assign push     = !rst && state == IDLE && !read_not_write;
    assign pop      = !rst && hasWrite && bus.mem_ack;

    cpu_write_buffer #(.DEPTH(WB_DEPTH)) wbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pushEntry ('{addr: coreAddr, data: data_from_cpu}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
`ifdef READ_BYPASS_EN
        ,
        .matchAddr (coreAddr),
        .matchHit  (matchHit),
        .matchData (matchData)
`endif
    );

`ifndef READ_BYPASS_EN
    assign matchHit  = 1'b0;
    assign matchData = 8'h00;
`endif

    // Opcode fetches always go to memory, never to the buffer.
    assign bypassHit = !rst && state == IDLE && read_not_write && !sync && matchHit;
    assign readIssue = !rst && (state == RD_WAIT ||
                       (state == IDLE && read_not_write && !hasWrite && !bypassHit));
    assign readAck   = readIssue && !hasWrite && bus.mem_ack;
    assign curAddr   = hasWrite ? head.addr : state == RD_WAIT ? rdAddr : coreAddr;

    // Buffered writes always win the port, which keeps reads behind them.
    assign bus.mem_req   = !rst && (hasWrite || readIssue);
    assign bus.mem_we    = rst ? 1'b0  : bus.mem_req ? hasWrite : lastWe;
    assign bus.mem_addr  = rst ? 16'h0 : bus.mem_req ? curAddr : lastAddr;
    assign bus.mem_wdata = rst ? 8'h00 : bus.mem_req && hasWrite ? head.data : lastWdata;

    assign ready       = !rst && (state == RD_DONE || (state == IDLE && !read_not_write));
    assign data_to_cpu = dataToCpu;
    assign wb_empty    = count == '0;
    assign wr_overflow = overflow;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (read_not_write) nextState = bypassHit || readAck ? RD_DONE :
                                                     hasWrite ? IDLE : RD_WAIT;
            RD_WAIT: nextState = readAck ? RD_DONE : RD_WAIT;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dataToCpu <= 8'h00;
            rdAddr    <= 16'h0;
            lastAddr  <= 16'h0;
            lastWe    <= 1'b0;
            lastWdata <= 8'h00;
            overflow  <= 1'b0;
        end else begin
            state <= nextState;
            if (readAck) dataToCpu <= bus.mem_rdata;
            else if (bypassHit) dataToCpu <= matchData;
            if (state == IDLE) rdAddr <= coreAddr;
            if (bus.mem_req) begin
                lastAddr  <= bus.mem_addr;
                lastWe    <= bus.mem_we;
                lastWdata <= bus.mem_wdata;
            end
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_bus_interface.sv
// tb_cpu_bus_interface: directed cycle-by-cycle checks of cpu_bus_interface; READ_BYPASS_EN adds bypass vectors.
module tb_cpu_bus_interface;

    logic        clk, rst, rnw, syncIn, ready, wbEmpty, wrOverflow;
    logic [15:0] addr;
    logic [7:0]  wdata, dataToCpu;
    int          checkCount = 0;
    int          passCount = 0;

    cpu_bus_if bus();

    cpu_bus_interface dut (
        .clk            (clk),
        .rst            (rst),
        .addr_high      (addr[15:8]),
        .addr_low       (addr[7:0]),
        .data_from_cpu  (wdata),
        .read_not_write (rnw),
        .sync           (syncIn),
        .ready          (ready),
        .data_to_cpu    (dataToCpu),
        .bus            (bus),
        .wb_empty       (wbEmpty),
        .wr_overflow    (wrOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passCount++;
    endtask

    // Advance one cycle, apply core/memory inputs, then settle to the falling edge.
    task automatic drive(input logic r, input logic [15:0] a, input logic [7:0] d,
                         input logic s, input logic ack, input logic [7:0] rd);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rnw = r;
        addr = a;
        wdata = d;
        syncIn = s;
        bus.mem_ack = ack;
        bus.mem_rdata = rd;
        @(negedge clk);
    endtask

    task automatic expWrite(input string tag, input logic [15:0] a, input logic [7:0] d);
        check({tag, "_req"}, bus.mem_req, 1);
        check({tag, "_we"}, bus.mem_we, 1);
        check({tag, "_addr"}, bus.mem_addr, a);
        check({tag, "_wdata"}, bus.mem_wdata, d);
        check({tag, "_ready"}, ready, 0);
    endtask

    task automatic expRead(input string tag, input logic [15:0] a);
        check({tag, "_req"}, bus.mem_req, 1);
        check({tag, "_we"}, bus.mem_we, 0);
        check({tag, "_addr"}, bus.mem_addr, a);
        check({tag, "_ready"}, ready, 0);
    endtask

    task automatic expDone(input string tag, input logic [7:0] d);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_data"}, dataToCpu, d);
    endtask

    initial begin
        rst = 1'b1;
        rnw = 1'b1;
        addr = 16'h0;
        wdata = 8'h00;
        syncIn = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 8'hEE;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_req", bus.mem_req, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_data", dataToCpu, 0);
        check("rst_empty", wbEmpty, 1);
        check("rst_ovf", wrOverflow, 0);

        drive(1, 16'hFFFC, 8'h00, 0, 1, 8'h34);
        expRead("zw0", 16'hFFFC);
        drive(1, 16'hFFFC, 8'h00, 0, 1, 8'h34);
        expDone("zw1", 8'h34);
        check("zw1_req", bus.mem_req, 0);
        check("zw1_hold", bus.mem_addr, 16'hFFFC);

        drive(0, 16'h01FF, 8'hAA, 0, 0, 8'h00);
        check("pw0_ready", ready, 1);
        check("pw0_req", bus.mem_req, 0);
        drive(0, 16'h01FE, 8'hBB, 0, 0, 8'h00);
        check("pw1_ready", ready, 1);
        check("pw1_empty", wbEmpty, 0);
        drive(0, 16'h01FD, 8'hCC, 0, 0, 8'h00);
        check("pw2_ready", ready, 1);
        drive(1, 16'h0300, 8'h00, 0, 1, 8'h77);
        expWrite("dr0", 16'h01FF, 8'hAA);
        drive(1, 16'h0300, 8'h00, 0, 1, 8'h77);
        expWrite("dr1", 16'h01FE, 8'hBB);
        drive(1, 16'h0300, 8'h00, 0, 1, 8'h77);
        expWrite("dr2", 16'h01FD, 8'hCC);
        drive(1, 16'h0300, 8'h00, 0, 1, 8'h77);
        expRead("dr3", 16'h0300);
        check("dr3_empty", wbEmpty, 1);
        drive(1, 16'h0300, 8'h00, 0, 1, 8'h77);
        expDone("dr4", 8'h77);

        drive(0, 16'h0400, 8'h11, 0, 0, 8'h00);
        drive(0, 16'h0401, 8'h22, 0, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            drive(1, 16'h0200, 8'h00, 0, 0, 8'h5A);
            expWrite("ord_wait", 16'h0400, 8'h11);
        end
        drive(1, 16'h0200, 8'h00, 0, 1, 8'h5A);
        expWrite("ord0", 16'h0400, 8'h11);
        drive(1, 16'h0200, 8'h00, 0, 1, 8'h5A);
        expWrite("ord1", 16'h0401, 8'h22);
        drive(1, 16'h0200, 8'h00, 0, 1, 8'h5A);
        expRead("ord2", 16'h0200);
        drive(1, 16'h0200, 8'h00, 0, 1, 8'h5A);
        expDone("ord3", 8'h5A);

        for (int i = 0; i < 5; i++) begin
            drive(0, 16'h0500 + 16'(i), 8'hA0 + 8'(i), 0, 0, 8'h00);
            check("ovf_ready", ready, 1);
            check("ovf_pre", wrOverflow, 0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'h0600, 8'h00, 0, 1, 8'h3C);
            expWrite("ovf_drain", 16'h0500 + 16'(i), 8'hA0 + 8'(i));
            check("ovf_set", wrOverflow, 1);
        end
        drive(1, 16'h0600, 8'h00, 0, 1, 8'h3C);
        expRead("ovf_rd", 16'h0600);
        drive(1, 16'h0600, 8'h00, 0, 1, 8'h3C);
        expDone("ovf_done", 8'h3C);
        check("ovf_sticky", wrOverflow, 1);

        for (int i = 0; i < 3; i++) begin
            drive(1, 16'h1234, 8'h00, 0, 0, 8'h9C);
            expRead("ws_wait", 16'h1234);
        end
        drive(1, 16'h1234, 8'h00, 0, 1, 8'h9C);
        expRead("ws_ack", 16'h1234);
        drive(1, 16'h1234, 8'h00, 0, 1, 8'h9C);
        expDone("ws_done", 8'h9C);

        drive(0, 16'h0010, 8'h55, 0, 0, 8'h00);
        check("bp_wr_ready", ready, 1);
`ifdef READ_BYPASS_EN
        drive(1, 16'h0010, 8'h00, 0, 0, 8'h66);
        expWrite("bp0", 16'h0010, 8'h55);
        drive(1, 16'h0010, 8'h00, 0, 0, 8'h66);
        expDone("bp1", 8'h55);
        check("bp1_empty", wbEmpty, 0);
`endif
        drive(1, 16'h0010, 8'h00, 1, 0, 8'h66);
        expWrite("fetch0", 16'h0010, 8'h55);
        drive(1, 16'h0010, 8'h00, 1, 1, 8'h66);
        expWrite("fetch1", 16'h0010, 8'h55);
        drive(1, 16'h0010, 8'h00, 1, 1, 8'h66);
        expRead("fetch2", 16'h0010);
        drive(1, 16'h0010, 8'h00, 1, 1, 8'h66);
        expDone("fetch3", 8'h66);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
